// File: rtl/vedic_dot_accum.sv
// vedic_dot_accum: sums every LEN consecutive unsigned multiplier products into one dot-product term.
// Latency: dot_valid rises right after the edge that accepts the LEN-th product (FIFO empty).
// Backpressure: none toward the multiplier; a completed sum that meets a full 2-entry FIFO with no pop is dropped and sets overflow.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   prod_in, prod_valid - product from the multiplier, qualified for one cycle
//   clear               - synchronous flush of partial sum, count, overflow, acc_wrap (FIFO untouched)
//   dot_out, dot_valid  - FIFO head and non-empty flag
//   dot_ready           - consumer accepts the head entry
//   count               - products in the current partial sum
//   overflow            - sticky: a completed sum was dropped
//   acc_wrap            - sticky: accumulator carried out of bit ACC_W-1
//
// Optional feature: define VEDIC_DOT_SAT_EN for a saturating accumulator
// (default build wraps modulo 2^ACC_W). ACC_W must be >= PROD_W and LEN >= 1.

module vedic_dot_accum #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int LEN    = 8,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              clear,
  output logic [ACC_W-1:0]  dot_out,
  output logic              dot_valid,
  input  logic              dot_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              acc_wrap
);

  typedef enum logic {ST_ACC, ST_EMIT} state_t;

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_base;
  logic [CNT_W-1:0] cnt_base;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_val;
  logic             carry;
  logic             accept;
  logic             last;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_en;
  logic             drop;

  logic [ACC_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       occ;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign accept = prod_valid & ~clear;

  // In EMIT the previous sum has just left; acc/count are already zero, so
  // the next product always starts a fresh sum.
  assign acc_base = (state == ST_EMIT) ? '0 : acc;
  assign cnt_base = (state == ST_EMIT) ? '0 : count;
  assign last     = (cnt_base == CNT_W'(LEN - 1));

  assign sum_ext = {1'b0, acc_base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_in};
  assign carry   = sum_ext[ACC_W];

`ifdef VEDIC_DOT_SAT_EN
  // Once pinned at all-ones any further add carries again, so acc stays put.
  assign sum_val = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign sum_val = sum_ext[ACC_W-1:0];
`endif

  assign push  = accept & last;
  assign pop   = dot_valid & dot_ready;
  assign full  = (occ == 2'd2);
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACC;
    else        state <= state_nxt;
  end

  // EMIT normally lasts one cycle; with LEN=1 a product accepted in EMIT
  // completes another sum immediately, which re-enters EMIT.
  always_comb begin
    state_nxt = ST_ACC;
    if (push) state_nxt = ST_EMIT;
  end

  // ---------------------------------------------------------------------------
  // Accumulator, count and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      acc_wrap <= 1'b0;
    end else if (clear) begin
      acc      <= '0;
      count    <= '0;
      overflow <= 1'b0;
      acc_wrap <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          acc   <= '0;
          count <= '0;
        end else begin
          acc   <= sum_val;
          count <= cnt_base + CNT_W'(1);
        end
        if (carry) acc_wrap <= 1'b1;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry output FIFO; a push into a full FIFO is kept only if the head
  // pops on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= sum_val;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({wr_en, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign dot_valid = (occ != 2'd0);
  assign dot_out   = dot_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_vedic_dot_accum.sv
module tb_vedic_dot_accum;

  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // LEN=4, default widths
  logic [63:0] a_prod;
  logic        a_vld, a_clr, a_rdy;
  logic [71:0] a_dot;
  logic        a_dv, a_ovf, a_wrap;
  logic [2:0]  a_cnt;

  // LEN=1, default widths
  logic [63:0] b_prod;
  logic        b_vld, b_clr, b_rdy;
  logic [71:0] b_dot;
  logic        b_dv, b_ovf, b_wrap;
  logic [0:0]  b_cnt;

  // LEN=8, ACC_W=66
  logic [63:0] c_prod;
  logic        c_vld, c_clr, c_rdy;
  logic [65:0] c_dot;
  logic        c_dv, c_ovf, c_wrap;
  logic [3:0]  c_cnt;

  vedic_dot_accum #(.PROD_W(64), .ACC_W(72), .LEN(4)) u_len4 (
    .clk(clk), .rst_n(rst_n), .prod_in(a_prod), .prod_valid(a_vld), .clear(a_clr),
    .dot_out(a_dot), .dot_valid(a_dv), .dot_ready(a_rdy), .count(a_cnt),
    .overflow(a_ovf), .acc_wrap(a_wrap));

  vedic_dot_accum #(.PROD_W(64), .ACC_W(72), .LEN(1)) u_len1 (
    .clk(clk), .rst_n(rst_n), .prod_in(b_prod), .prod_valid(b_vld), .clear(b_clr),
    .dot_out(b_dot), .dot_valid(b_dv), .dot_ready(b_rdy), .count(b_cnt),
    .overflow(b_ovf), .acc_wrap(b_wrap));

  vedic_dot_accum #(.PROD_W(64), .ACC_W(66), .LEN(8)) u_wide (
    .clk(clk), .rst_n(rst_n), .prod_in(c_prod), .prod_valid(c_vld), .clear(c_clr),
    .dot_out(c_dot), .dot_valid(c_dv), .dot_ready(c_rdy), .count(c_cnt),
    .overflow(c_ovf), .acc_wrap(c_wrap));

  typedef struct {
    logic        pv;
    logic [63:0] prod;
    logic        clr;
    logic        rdy;
    logic [2:0]  e_cnt;
    logic        e_vld;
    logic [71:0] e_dot;
    logic        e_ovf;
    logic        e_wrap;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;

  logic [65:0] wide_exp;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic pv, input logic [63:0] prod, input logic clr,
                     input logic [2:0] cnt, input logic vld, input logic [71:0] dot);
    vec_t v;
    v.pv = pv; v.prod = prod; v.clr = clr; v.rdy = 1'b1;
    v.e_cnt = cnt; v.e_vld = vld; v.e_dot = dot; v.e_ovf = 1'b0; v.e_wrap = 1'b0;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
`ifdef VEDIC_DOT_SAT_EN
    wide_exp = {66{1'b1}};
`else
    wide_exp = {2'b11, {60{1'b1}}, 4'h8};
`endif

    // LEN=4 table: basic sum, back-to-back, clear collision
    add(1, 1, 0, 1, 0, 0);
    add(1, 2, 0, 2, 0, 0);
    add(1, 3, 0, 3, 0, 0);
    add(1, 4, 0, 0, 1, 10);
    add(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(1, 5, 0, 3'((i + 1) % 4), ((i % 4) == 3), (((i % 4) == 3) ? 72'd20 : 72'd0));
    add(0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0);
    add(1, 2, 0, 2, 0, 0);
    add(1, 100, 1, 0, 0, 0);
    add(1, 3, 0, 1, 0, 0);
    add(1, 4, 0, 2, 0, 0);
    add(1, 5, 0, 3, 0, 0);
    add(1, 6, 0, 0, 1, 18);
    add(0, 0, 0, 0, 0, 0);

    rst_n = 1'b0;
    a_prod = '0; a_vld = 0; a_clr = 0; a_rdy = 1;
    b_prod = '0; b_vld = 0; b_clr = 0; b_rdy = 0;
    c_prod = '0; c_vld = 0; c_clr = 0; c_rdy = 1;
    #3;
    chk("reset a_dot", a_dot, 0);
    chk("reset a_valid", a_dv, 0);
    chk("reset a_count", a_cnt, 0);
    chk("reset a_overflow", a_ovf, 0);
    chk("reset a_acc_wrap", a_wrap, 0);
    chk("reset b_valid", b_dv, 0);
    chk("reset c_valid", c_dv, 0);
    #10;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      a_vld = tbl[i].pv; a_prod = tbl[i].prod; a_clr = tbl[i].clr; a_rdy = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d count", i), a_cnt, tbl[i].e_cnt);
      chk($sformatf("vec%0d dot_valid", i), a_dv, tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("vec%0d dot_out", i), a_dot, tbl[i].e_dot);
      chk($sformatf("vec%0d overflow", i), a_ovf, tbl[i].e_ovf);
      chk($sformatf("vec%0d acc_wrap", i), a_wrap, tbl[i].e_wrap);
    end
    a_vld = 0; a_clr = 0;

    // LEN=1 backpressure: 7 and 8 held, 9 dropped
    b_vld = 1; b_prod = 7;
    tick();
    chk("bp push7 valid", b_dv, 1);
    chk("bp push7 dot", b_dot, 7);
    chk("bp push7 count", b_cnt, 0);
    b_prod = 8;
    tick();
    chk("bp push8 dot held", b_dot, 7);
    chk("bp push8 overflow", b_ovf, 0);
    b_prod = 9;
    tick();
    chk("bp push9 dot held", b_dot, 7);
    chk("bp push9 overflow", b_ovf, 1);
    b_vld = 0;
    tick();
    chk("bp idle valid", b_dv, 1);
    chk("bp idle dot", b_dot, 7);
    b_rdy = 1;
    #1;
    chk("bp drain head 7", b_dot, 7);
    tick();
    chk("bp drain valid 8", b_dv, 1);
    chk("bp drain head 8", b_dot, 8);
    tick();
    chk("bp drained valid", b_dv, 0);
    chk("bp overflow sticky", b_ovf, 1);
    b_clr = 1;
    tick();
    chk("bp clear overflow", b_ovf, 0);
    b_clr = 0;

    // ACC_W=66 width limit
    for (int i = 0; i < 8; i++) begin
      c_vld = 1; c_prod = {64{1'b1}};
      tick();
      if (i == 3) chk("wide wrap before carry", c_wrap, 0);
      if (i == 4) chk("wide wrap on carry", c_wrap, 1);
      if (i < 7) chk($sformatf("wide valid early %0d", i), c_dv, 0);
    end
    c_vld = 0;
    chk("wide valid", c_dv, 1);
    chk("wide dot", c_dot, wide_exp);
    chk("wide acc_wrap", c_wrap, 1);
    chk("wide count", c_cnt, 0);
    tick();
    chk("wide popped", c_dv, 0);

    // Reset mid-sum with a sum pending in the FIFO
    a_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      a_vld = 1; a_prod = 1;
      tick();
    end
    chk("pre-reset valid", a_dv, 1);
    chk("pre-reset dot", a_dot, 4);
    for (int i = 0; i < 3; i++) begin
      a_vld = 1; a_prod = 2;
      tick();
    end
    a_vld = 0;
    chk("pre-reset count", a_cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("mid-reset valid", a_dv, 0);
    chk("mid-reset dot", a_dot, 0);
    chk("mid-reset count", a_cnt, 0);
    chk("mid-reset c_acc_wrap", c_wrap, 0);
    #1;
    rst_n = 1'b1;
    a_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      a_vld = 1; a_prod = 1;
      tick();
    end
    a_vld = 0;
    chk("post-reset valid", a_dv, 1);
    chk("post-reset dot", a_dot, 4);
    chk("post-reset count", a_cnt, 0);
    tick();
    chk("post-reset popped", a_dv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
